// File: rtl/spi_slave.sv
// SPI responder for the 8-bit link: oversampled sclk/ssn/mosi, MSB-first shifting,
// one-deep transmit buffer (ready/load) and received-byte register (valid/ack).
`timescale 1ns/1ps
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DUMMY       = 8'h00
) (
  input  logic       reset,
  input  logic       clock_in,
  input  logic       sclk,
  input  logic       ssn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       frame_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ssn_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_d1_q;
  logic                   ssn_d1_q;

  state_e              state_q;
  logic [BYTE_W-1:0]   shreg_q;
  logic [CNT_W-1:0]    bitcnt_q;
  logic [BYTE_W-1:0]   tx_buf_q;
  logic                tx_ready_q;
  logic                miso_q;
  logic                miso_oe_q;
  logic [BYTE_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                rx_overrun_q;
  logic                frame_err_q;

  logic                sclk_s;
  logic                ssn_s;
  logic                mosi_s;
  logic                sclk_fall_c;
  logic                ssn_fall_c;
  logic                ssn_rise_c;
  logic [BYTE_W-1:0]   shift_c;
  logic [BYTE_W-1:0]   reload_c;

  // Metastability chains; ssn resets to deselected.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ssn_sync_q  <= '1;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], ssn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ssn_s  = ssn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_fall_c = sclk_d1_q & ~sclk_s;
  assign ssn_fall_c  = ssn_d1_q & ~ssn_s;
  assign ssn_rise_c  = ~ssn_d1_q & ssn_s;

  assign shift_c  = {shreg_q[BYTE_W-2:0], mosi_s};
  // Buffered byte if present, otherwise the filler byte.
  assign reload_c = tx_ready_q ? DUMMY : tx_buf_q;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sclk_d1_q    <= 1'b0;
      ssn_d1_q     <= 1'b1;
      state_q      <= IDLE;
      shreg_q      <= DUMMY;
      bitcnt_q     <= '0;
      tx_buf_q     <= '0;
      tx_ready_q   <= 1'b1;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_d1_q   <= sclk_s;
      ssn_d1_q    <= ssn_s;
      frame_err_q <= 1'b0;

      if (rx_ack) begin
        rx_valid_q   <= 1'b0;
        rx_overrun_q <= 1'b0;
      end

      // A load only lands in an empty buffer, so it never races a consume.
      if (tx_load && tx_ready_q) begin
        tx_buf_q   <= tx_data;
        tx_ready_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          if (ssn_fall_c) begin
            state_q   <= ACTIVE;
            shreg_q   <= reload_c;
            miso_q    <= reload_c[BYTE_W-1];
            miso_oe_q <= 1'b1;
            bitcnt_q  <= '0;
            if (!tx_ready_q) tx_ready_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ssn_rise_c) begin
            // Deselect wins over a coincident sclk fall; partial byte is dropped.
            state_q   <= IDLE;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            bitcnt_q  <= '0;
            if (bitcnt_q != '0) frame_err_q <= 1'b1;
          end else if (sclk_fall_c) begin
            if (bitcnt_q == LAST_BIT) begin
              rx_data_q    <= shift_c;
              rx_valid_q   <= 1'b1;
              rx_overrun_q <= ~rx_ack & (rx_overrun_q | rx_valid_q);
              bitcnt_q     <= '0;
              shreg_q      <= reload_c;
              miso_q       <= reload_c[BYTE_W-1];
              if (!tx_ready_q) tx_ready_q <= 1'b1;
            end else begin
              shreg_q  <= shift_c;
              miso_q   <= shift_c[BYTE_W-1];
              bitcnt_q <= bitcnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = miso_oe_q;
  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged SPI master with hand-computed expectations.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int unsigned HALF = 8;

  logic       reset;
  logic       clock_in;
  logic       sclk;
  logic       ssn;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       frame_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned fe_cnt = 0;
  logic [7:0]  mi;

  spi_slave dut (
    .reset      (reset),
    .clock_in   (clock_in),
    .sclk       (sclk),
    .ssn        (ssn),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Counts clock_in cycles with frame_err high.
  always @(negedge clock_in) if (frame_err === 1'b1) fe_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    tick(1);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    tick(1);
  endtask

  // Master shifts nbits MSB-first; mosi changes at sclk rise, miso sampled just before rise.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit ack_last,
                      output logic [7:0] got);
    got = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      tick(HALF);
      got[i] = miso;
      sclk = 1'b1;
      mosi = mo[i];
      tick(HALF);
      sclk = 1'b0;
    end
    if (ack_last) begin
      // Lands rx_ack on the same clock edge that registers the byte.
      tick(2);
      rx_ack = 1'b1;
      tick(1);
      rx_ack = 1'b0;
    end
    tick(HALF);
  endtask

  task automatic sel(input logic v);
    ssn = v;
    tick(HALF);
  endtask

  initial begin
    reset = 1'b1; sclk = 1'b0; ssn = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_load = 1'b0; rx_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);

    chk1("rst_miso", miso, 1'b0);
    chk1("rst_miso_oe", miso_oe, 1'b0);
    chk1("rst_tx_ready", tx_ready, 1'b1);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_rx_overrun", rx_overrun, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);

    // Single byte with buffered transmit data.
    load(8'hA5);
    chk1("t1_tx_ready_after_load", tx_ready, 1'b0);
    sel(1'b0);
    chk1("t1_miso_oe", miso_oe, 1'b1);
    chk1("t1_miso_msb_first", miso, 1'b1);
    chk1("t1_tx_ready_consumed", tx_ready, 1'b1);
    xfer(8'h3C, 8, 1'b0, mi);
    chk8("t1_miso_byte", mi, 8'hA5);
    chk8("t1_rx_data", rx_data, 8'h3C);
    chk1("t1_rx_valid", rx_valid, 1'b1);
    sel(1'b1);
    chk1("t1_miso_oe_idle", miso_oe, 1'b0);
    chk8("t1_no_frame_err", 8'(fe_cnt), 8'd0);
    ack();
    chk1("t1_rx_valid_acked", rx_valid, 1'b0);

    // Nothing buffered: filler byte goes out.
    sel(1'b0);
    xfer(8'hFF, 8, 1'b0, mi);
    chk8("t2_miso_dummy", mi, 8'h00);
    chk8("t2_rx_data", rx_data, 8'hFF);
    sel(1'b1);
    ack();

    // Back-to-back bytes in one frame, no ack in between.
    load(8'h81);
    sel(1'b0);
    load(8'h7E);
    chk1("t3_tx_ready_second_load", tx_ready, 1'b0);
    xfer(8'h11, 8, 1'b0, mi);
    chk8("t3_miso_first", mi, 8'h81);
    chk1("t3_no_overrun_yet", rx_overrun, 1'b0);
    xfer(8'h22, 8, 1'b0, mi);
    chk8("t3_miso_second", mi, 8'h7E);
    chk8("t3_rx_data", rx_data, 8'h22);
    chk1("t3_rx_valid", rx_valid, 1'b1);
    chk1("t3_rx_overrun", rx_overrun, 1'b1);
    chk1("t3_tx_ready", tx_ready, 1'b1);
    sel(1'b1);
    ack();
    chk1("t3_valid_cleared", rx_valid, 1'b0);
    chk1("t3_overrun_cleared", rx_overrun, 1'b0);

    // Aborted frame after five bits, then a clean frame.
    sel(1'b0);
    xfer(8'hA0, 5, 1'b0, mi);
    sel(1'b1);
    chk8("t4_frame_err_one_cycle", 8'(fe_cnt), 8'd1);
    chk8("t4_rx_data_kept", rx_data, 8'h22);
    chk1("t4_rx_valid_kept", rx_valid, 1'b0);
    sel(1'b0);
    xfer(8'h5A, 8, 1'b0, mi);
    chk8("t4_miso_dummy", mi, 8'h00);
    chk8("t4_rx_data_restart", rx_data, 8'h5A);
    chk1("t4_rx_valid", rx_valid, 1'b1);
    sel(1'b1);
    chk8("t4_no_extra_frame_err", 8'(fe_cnt), 8'd1);

    // Load collision and ack coincident with byte complete (5A still unacked).
    load(8'h33);
    chk1("t5_tx_ready_first", tx_ready, 1'b0);
    load(8'h44);
    chk1("t5_tx_ready_ignored", tx_ready, 1'b0);
    sel(1'b0);
    xfer(8'hC3, 8, 1'b1, mi);
    chk8("t5_miso_kept_first", mi, 8'h33);
    chk8("t5_rx_data", rx_data, 8'hC3);
    chk1("t5_rx_valid_new_wins", rx_valid, 1'b1);
    chk1("t5_rx_overrun_cleared", rx_overrun, 1'b0);
    sel(1'b1);
    ack();

    // Reset in the middle of a byte.
    load(8'h99);
    sel(1'b0);
    xfer(8'hF0, 3, 1'b0, mi);
    chk1("t6_miso_before_reset", miso, 1'b1);
    reset = 1'b1;
    ssn = 1'b1;
    #1;
    chk1("t6_miso", miso, 1'b0);
    chk1("t6_miso_oe", miso_oe, 1'b0);
    chk1("t6_tx_ready", tx_ready, 1'b1);
    chk8("t6_rx_data", rx_data, 8'h00);
    chk1("t6_rx_valid", rx_valid, 1'b0);
    chk1("t6_rx_overrun", rx_overrun, 1'b0);
    tick(3);
    reset = 1'b0;
    tick(2 * HALF);
    chk8("t6_no_frame_err", 8'(fe_cnt), 8'd1);
    chk1("t6_tx_ready_after", tx_ready, 1'b1);
    chk1("t6_miso_oe_after", miso_oe, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
